// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

  localparam int unsigned PRIO_RR          = 0;
  localparam int unsigned PRIO_FIXED       = 1;
  localparam int unsigned MAX_READ_LATENCY = 4;
  // Counter holds READ_LATENCY-1, so 2 bits cover the legal range.
  localparam int unsigned CNT_W            = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input winner select plus the last_grant history register.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int unsigned PRIORITY_MODE = PRIO_RR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       any_req,
  output req_id_t    winner,
  output req_id_t    last_grant
);

  always_comb begin
    any_req = |req;
    winner  = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = (PRIORITY_MODE == PRIO_FIXED) ? 1'b0 : ~last_grant;
      default: winner = 1'b0;
    endcase
  end

  // Resetting to 1 hands m0 the first contested grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises m0/m1 transactions onto one synchronous memory port and routes read completions.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned PRIORITY_MODE = PRIO_RR,
  parameter int unsigned ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wr_data,
  input  logic              m0_wr_ena,
  output logic              m0_gnt,
  output logic [31:0]       m0_rd_data,
  output logic              m0_rd_valid,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wr_data,
  input  logic              m1_wr_ena,
  output logic              m1_gnt,
  output logic [31:0]       m1_rd_data,
  output logic              m1_rd_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  output logic              mem_wr_ena,
  input  logic [31:0]       mem_rd_data,
  output logic              busy,
  output logic              last_grant
);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("mem_port_arbiter: READ_LATENCY must be in 1..%0d", MAX_READ_LATENCY);
  end

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY - 1);

  arb_state_t        state;
  logic [CNT_W-1:0]  cnt;
  req_id_t           owner;
  logic [ADDR_W-1:0] rd_addr;

  logic              any_req;
  req_id_t           winner;
  logic              take;
  logic [ADDR_W-1:0] win_addr;
  logic [31:0]       win_wdata;
  logic              win_we;

  assign take      = !rst && ena && (state == IDLE) && any_req;
  assign win_addr  = winner ? m1_addr    : m0_addr;
  assign win_wdata = winner ? m1_wr_data : m0_wr_data;
  assign win_we    = winner ? m1_wr_ena  : m0_wr_ena;

  rr_arb2 #(.PRIORITY_MODE(PRIORITY_MODE)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        ({m1_req, m0_req}),
    .advance    (take),
    .any_req    (any_req),
    .winner     (winner),
    .last_grant (last_grant)
  );

  assign m0_rd_data = mem_rd_data;
  assign m1_rd_data = mem_rd_data;

  // Outputs are forced to reset values while rst is high so a read due
  // in the reset cycle is dropped rather than reported.
  always_comb begin
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    m0_rd_valid = 1'b0;
    m1_rd_valid = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_ena  = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      if (state == RD_WAIT) begin
        busy     = 1'b1;
        mem_addr = rd_addr;
        if (cnt == '0) begin
          m0_rd_valid = (owner == 1'b0);
          m1_rd_valid = (owner == 1'b1);
        end
      end else if (take) begin
        m0_gnt      = (winner == 1'b0);
        m1_gnt      = (winner == 1'b1);
        mem_addr    = win_addr;
        mem_wr_data = win_wdata;
        mem_wr_ena  = win_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      owner   <= 1'b0;
      rd_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take && !win_we) begin
            state   <= RD_WAIT;
            cnt     <= LAT_LOAD;
            owner   <= winner;
            rd_addr <= win_addr;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter across several latency/priority configurations.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int NI   = 4;
  localparam int NCYC = 2000;
  localparam int unsigned RL_T [NI] = '{1, 3, 2, 4};
  localparam int unsigned PM_T [NI] = '{0, 1, 0, 1};

  typedef struct {
    int unsigned cyc;
    bit          id;
    bit          we;
  } grant_t;

  typedef struct {
    int unsigned cyc;
    bit          id;
    logic [31:0] data;
  } rd_t;

  typedef struct {
    bit          busy;
    bit          last;
    logic [31:0] addr;
    bit          chk_wdata;
    logic [31:0] wdata;
  } status_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  logic mem_init = 1'b1;

  logic        m0_req [NI], m0_wr_ena [NI], m0_gnt [NI], m0_rd_valid [NI];
  logic        m1_req [NI], m1_wr_ena [NI], m1_gnt [NI], m1_rd_valid [NI];
  logic [31:0] m0_addr [NI], m0_wr_data [NI], m0_rd_data [NI];
  logic [31:0] m1_addr [NI], m1_wr_data [NI], m1_rd_data [NI];
  logic [31:0] mem_addr [NI], mem_wr_data [NI], mem_rd_data [NI];
  logic        mem_wr_ena [NI], busy [NI], last_grant [NI];

  logic [31:0] mem  [NI][32];
  logic [31:0] pipe [NI][4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter #(
      .READ_LATENCY  (RL_T[g]),
      .PRIORITY_MODE (PM_T[g]),
      .ADDR_W        (32)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .m0_req      (m0_req[g]),
      .m0_addr     (m0_addr[g]),
      .m0_wr_data  (m0_wr_data[g]),
      .m0_wr_ena   (m0_wr_ena[g]),
      .m0_gnt      (m0_gnt[g]),
      .m0_rd_data  (m0_rd_data[g]),
      .m0_rd_valid (m0_rd_valid[g]),
      .m1_req      (m1_req[g]),
      .m1_addr     (m1_addr[g]),
      .m1_wr_data  (m1_wr_data[g]),
      .m1_wr_ena   (m1_wr_ena[g]),
      .m1_gnt      (m1_gnt[g]),
      .m1_rd_data  (m1_rd_data[g]),
      .m1_rd_valid (m1_rd_valid[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wr_data (mem_wr_data[g]),
      .mem_wr_ena  (mem_wr_ena[g]),
      .mem_rd_data (mem_rd_data[g]),
      .busy        (busy[g]),
      .last_grant  (last_grant[g])
    );
  end

  function automatic logic [31:0] init_word(int a);
    return (a == 16) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(a));
  endfunction

  // Memory with a READ_LATENCY-deep read pipeline per instance.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (mem_init) begin
        for (int a = 0; a < 32; a++) mem[g][a] <= init_word(a);
      end else if (mem_wr_ena[g]) begin
        mem[g][mem_addr[g][4:0]] <= mem_wr_data[g];
      end
      pipe[g][0] <= mem[g][mem_addr[g][4:0]];
      for (int k = 1; k < 4; k++) pipe[g][k] <= pipe[g][k-1];
    end
  end

  always_comb begin
    for (int g = 0; g < NI; g++) mem_rd_data[g] = pipe[g][RL_T[g]-1];
  end

  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  grant_t  gq [NI][$];
  rd_t     rq [NI][$];
  status_t sq [NI][$];

  task automatic chk(string what, int g, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d cyc%0d: got 0x%08h want 0x%08h", what, g, cyc, act, exp);
  endtask

  // Reference model state: requester intents plus transaction-level port bookkeeping.
  bit          act   [NI][2];
  logic [31:0] raddr [NI][2];
  logic [31:0] rwd   [NI][2];
  bit          rwe   [NI][2];
  bit          mlast [NI];
  int unsigned free_c [NI];
  logic [31:0] hold_addr [NI];
  logic [31:0] mmem [NI][32];

  task automatic new_req(int g, int r, bit we, logic [31:0] a);
    act[g][r]   = 1'b1;
    rwe[g][r]   = we;
    raddr[g][r] = a;
    rwd[g][r]   = $urandom;
  endtask

  task automatic model_step(int g, int unsigned c);
    status_t s;
    grant_t  e;
    rd_t     r;
    bit      w;
    s.busy = 1'b0;
    s.last = mlast[g];
    s.addr = '0;
    s.chk_wdata = 1'b0;
    s.wdata = '0;
    if (rst) begin
      rq[g].delete();
      mlast[g]  = 1'b1;
      free_c[g] = c + 1;
      s.chk_wdata = 1'b1;
    end else if (c < free_c[g]) begin
      s.busy = 1'b1;
      s.addr = hold_addr[g];
    end else if (ena && (act[g][0] || act[g][1])) begin
      if (act[g][0] && act[g][1]) w = (PM_T[g] == 1) ? 1'b0 : !mlast[g];
      else w = act[g][1];
      e.cyc = c;
      e.id  = w;
      e.we  = rwe[g][w];
      gq[g].push_back(e);
      s.addr = raddr[g][w];
      s.chk_wdata = 1'b1;
      s.wdata = rwd[g][w];
      mlast[g] = w;
      if (rwe[g][w]) begin
        mmem[g][raddr[g][w][4:0]] = rwd[g][w];
      end else begin
        r.cyc  = c + RL_T[g];
        r.id   = w;
        r.data = mmem[g][raddr[g][w][4:0]];
        rq[g].push_back(r);
        free_c[g]    = c + RL_T[g] + 1;
        hold_addr[g] = raddr[g][w];
      end
      act[g][w] = 1'b0;
    end else begin
      s.chk_wdata = 1'b1;
    end
    sq[g].push_back(s);
  endtask

  initial begin : stimulus
    for (int g = 0; g < NI; g++) begin
      mlast[g] = 1'b1;
      free_c[g] = 0;
      hold_addr[g] = '0;
      for (int a = 0; a < 32; a++) mmem[g][a] = init_word(a);
      for (int r = 0; r < 2; r++) act[g][r] = 1'b0;
      m0_req[g] = 1'b0; m0_addr[g] = '0; m0_wr_data[g] = '0; m0_wr_ena[g] = 1'b0;
      m1_req[g] = 1'b0; m1_addr[g] = '0; m1_wr_data[g] = '0; m1_wr_ena[g] = 1'b0;
    end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      mem_init = 1'b0;
      rst = (c < 2) || (c >= 40 && c < NCYC - 40 && $urandom_range(0, 99) == 0);
      ena = !(c >= 25 && c < 28) &&
            !(c >= 28 && c < NCYC - 40 && $urandom_range(0, 9) == 0);
      for (int g = 0; g < NI; g++) begin
        for (int r = 0; r < 2; r++) begin
          if (c == 2 && r == 0) begin
            new_req(g, 0, 1'b0, 32'h10);
          end else if (((c >= 10 && c < 18) || c == 25) && !act[g][r]) begin
            new_req(g, r, 1'b1, 32'($urandom_range(0, 31)));
          end else if (c >= 28 && c < NCYC - 30) begin
            if (!act[g][r] && $urandom_range(0, 2) == 0)
              new_req(g, r, bit'($urandom_range(0, 1)), 32'($urandom_range(0, 31)));
            else if (act[g][r] && $urandom_range(0, 19) == 0)
              act[g][r] = 1'b0;
          end
        end
        m0_req[g]     = act[g][0];
        m0_addr[g]    = act[g][0] ? raddr[g][0] : $urandom;
        m0_wr_data[g] = act[g][0] ? rwd[g][0]   : $urandom;
        m0_wr_ena[g]  = act[g][0] ? rwe[g][0]   : bit'($urandom_range(0, 1));
        m1_req[g]     = act[g][1];
        m1_addr[g]    = act[g][1] ? raddr[g][1] : $urandom;
        m1_wr_data[g] = act[g][1] ? rwd[g][1]   : $urandom;
        m1_wr_ena[g]  = act[g][1] ? rwe[g][1]   : bit'($urandom_range(0, 1));
        model_step(g, c);
      end
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      for (int a = 0; a < 32; a++) chk("mem_contents", g, mem[g][a], mmem[g][a]);
      chk("grants_outstanding", g, 32'(gq[g].size()), 32'd0);
      chk("reads_outstanding", g, 32'(rq[g].size()), 32'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  task automatic check_inst(int g);
    status_t     s;
    grant_t      e;
    rd_t         r;
    logic [1:0]  gv;
    logic [1:0]  rv;
    gv = {m1_gnt[g], m0_gnt[g]};
    rv = {m1_rd_valid[g], m0_rd_valid[g]};
    if (sq[g].size() != 0) begin
      s = sq[g].pop_front();
      chk("busy", g, 32'(busy[g]), 32'(s.busy));
      chk("last_grant", g, 32'(last_grant[g]), 32'(s.last));
      chk("mem_addr", g, mem_addr[g], s.addr);
      if (s.chk_wdata) chk("mem_wr_data", g, mem_wr_data[g], s.wdata);
    end
    if (gq[g].size() != 0 && gq[g][0].cyc == cyc) begin
      e = gq[g].pop_front();
      chk("gnt", g, 32'(gv), e.id ? 32'd2 : 32'd1);
      chk("mem_wr_ena", g, 32'(mem_wr_ena[g]), 32'(e.we));
    end else begin
      chk("gnt_idle", g, 32'(gv), 32'd0);
      chk("mem_wr_ena_idle", g, 32'(mem_wr_ena[g]), 32'd0);
    end
    if (rq[g].size() != 0 && rq[g][0].cyc == cyc) begin
      r = rq[g].pop_front();
      chk("rd_valid", g, 32'(rv), r.id ? 32'd2 : 32'd1);
      chk("rd_data", g, r.id ? m1_rd_data[g] : m0_rd_data[g], r.data);
    end else begin
      chk("rd_valid_idle", g, 32'(rv), 32'd0);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) check_inst(g);
    end
  end

endmodule
